// File: rtl/id_exe_mem_pipe_pkg.sv
// id_exe_mem_pipe_pkg
//   Shared definitions for the ID/EX/MEM pipeline slice:
//   word widths, instruction field positions, opcode constants
//   and the stage-register structs.
package id_exe_mem_pipe_pkg;

  localparam int DATA_W    = 16;
  localparam int MEM_DEPTH = 16;
  localparam int INSTR_W   = 20;
  localparam int NPC_W     = 8;
  localparam int LINE_W    = 4;
  localparam int IMM_W     = 8;

  // Instruction field LSB positions (fields overlap; meaning depends on opcode)
  localparam int OPC_LSB  = 16;
  localparam int RD_LSB   = 12;
  localparam int RS1_LSB  = 8;
  localparam int RS2_LSB  = 4;
  localparam int IMM_LSB  = 0;
  localparam int LINE_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;

  // ID/EX register contents
  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [IMM_W-1:0]  imm;
    logic [LINE_W-1:0] line;
    logic [NPC_W-1:0]  npc;
  } stage_t;

  // EX/MEM register contents; op2 is carried as store data
  typedef struct packed {
    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [LINE_W-1:0] line;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] result;
    logic [NPC_W-1:0]  npc;
  } ex_stage_t;

  // Opcodes that write back an ALU result
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/id_exe_mem_pipe_alu.sv
// pipe_alu
//   Combinational ALU for the EX stage.
//   opcode_i : 4-bit opcode
//   op1_i    : R[rs1]
//   op2_i    : R[rs2]
//   imm_i    : 8-bit immediate (ADDI operand, shift amount in [3:0])
//   result_o : result, 0 for LD/ST/NOP and undefined opcodes
module pipe_alu
  import id_exe_mem_pipe_pkg::*;
(
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  input  logic [IMM_W-1:0]  imm_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (opcode_i)
      OP_ADD:  result_o = op1_i + op2_i;
      OP_SUB:  result_o = op1_i - op2_i;
      OP_ADDI: result_o = op1_i + {{(DATA_W-IMM_W){1'b0}}, imm_i};
      OP_AND:  result_o = op1_i & op2_i;
      OP_OR:   result_o = op1_i | op2_i;
      OP_XOR:  result_o = op1_i ^ op2_i;
      OP_NOT:  result_o = ~op1_i;
      OP_SHL:  result_o = op1_i << imm_i[3:0];
      OP_SHR:  result_o = op1_i >> imm_i[3:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/id_exe_mem_pipe_dmem.sv
// pipe_dmem
//   Data memory: synchronous write, synchronous clear, combinational read.
//   clk_i, rst_i : clock, synchronous active-high clear of every word
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : asynchronous read port (pre-edge contents)
module pipe_dmem #(
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 16,
  parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/id_exe_mem_pipe.sv
// id_exe_mem_pipe
//   ID -> EX -> MEM slice of the core. Operands are read from the external
//   register file values at the ID edge; write-back request leaves MEM.
//   clkwire, reset          : clock, synchronous active-high reset
//   regwire1..regwire8      : R0..R7
//   current_instruction     : instruction entering ID
//   npc_in                  : next-PC travelling with the instruction
//   ex_alu_output, ex_npc   : EX-stage observation
//   mem_npc                 : MEM-stage NPC
//   wb_valid/wb_reg/wb_data : write-back request
module id_exe_mem_pipe
  import id_exe_mem_pipe_pkg::*;
(
  input  logic               clkwire,
  input  logic               reset,
  input  logic [DATA_W-1:0]  regwire1,
  input  logic [DATA_W-1:0]  regwire2,
  input  logic [DATA_W-1:0]  regwire3,
  input  logic [DATA_W-1:0]  regwire4,
  input  logic [DATA_W-1:0]  regwire5,
  input  logic [DATA_W-1:0]  regwire6,
  input  logic [DATA_W-1:0]  regwire7,
  input  logic [DATA_W-1:0]  regwire8,
  input  logic [INSTR_W-1:0] current_instruction,
  input  logic [NPC_W-1:0]   npc_in,
  output logic [DATA_W-1:0]  ex_alu_output,
  output logic [NPC_W-1:0]   ex_npc,
  output logic [NPC_W-1:0]   mem_npc,
  output logic               wb_valid,
  output logic [3:0]         wb_reg,
  output logic [DATA_W-1:0]  wb_data
);

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        rs1_sel;
  logic [2:0]        rs2_sel;
  logic              unused_rs1_msb;

  stage_t            id_d, id_q;
  ex_stage_t         ex_d, ex_q;
  logic              wb_valid_d, wb_valid_q;
  logic [3:0]        wb_reg_d, wb_reg_q;
  logic [DATA_W-1:0] wb_data_d, wb_data_q;
  logic [NPC_W-1:0]  mem_npc_q;

  logic [DATA_W-1:0] alu_result;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign regs[0] = regwire1;
  assign regs[1] = regwire2;
  assign regs[2] = regwire3;
  assign regs[3] = regwire4;
  assign regs[4] = regwire5;
  assign regs[5] = regwire6;
  assign regs[6] = regwire7;
  assign regs[7] = regwire8;

  // Only eight registers exist, so index bit 3 is dropped. rs2[3] doubles
  // as imm8[7] and stays live; rs1[3] has no other use.
  assign rs1_sel        = current_instruction[RS1_LSB +: 3];
  assign rs2_sel        = current_instruction[RS2_LSB +: 3];
  assign unused_rs1_msb = current_instruction[RS1_LSB + 3];

  // ID
  always_comb begin
    id_d        = '0;
    id_d.opcode = current_instruction[OPC_LSB +: 4];
    id_d.rd     = current_instruction[RD_LSB +: 4];
    id_d.op1    = regs[rs1_sel];
    id_d.op2    = regs[rs2_sel];
    id_d.imm    = current_instruction[IMM_LSB +: IMM_W];
    id_d.line   = current_instruction[LINE_LSB +: LINE_W];
    id_d.npc    = npc_in;
  end

  // EX
  pipe_alu u_alu (
    .opcode_i (id_q.opcode),
    .op1_i    (id_q.op1),
    .op2_i    (id_q.op2),
    .imm_i    (id_q.imm),
    .result_o (alu_result)
  );

  always_comb begin
    ex_d        = '0;
    ex_d.opcode = id_q.opcode;
    ex_d.rd     = id_q.rd;
    ex_d.line   = id_q.line;
    ex_d.op2    = id_q.op2;
    ex_d.result = alu_result;
    ex_d.npc    = id_q.npc;
  end

  // MEM
  assign mem_we = (ex_q.opcode == OP_ST);

  pipe_dmem #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (LINE_W)
  ) u_dmem (
    .clk_i   (clkwire),
    .rst_i   (reset),
    .we_i    (mem_we),
    .waddr_i (ex_q.line),
    .wdata_i (ex_q.op2),
    .raddr_i (ex_q.line),
    .rdata_o (mem_rdata)
  );

  // The read is combinational, so an LD one slot behind an ST to the same
  // line already sees the value committed at the previous edge.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_reg_d   = '0;
    wb_data_d  = '0;
    if (is_alu_op(ex_q.opcode)) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = ex_q.rd;
      wb_data_d  = ex_q.result;
    end else if (ex_q.opcode == OP_LD) begin
      wb_valid_d = 1'b1;
      wb_reg_d   = ex_q.rd;
      wb_data_d  = mem_rdata;
    end
  end

  always_ff @(posedge clkwire) begin
    if (reset) begin
      id_q       <= '0;
      ex_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      mem_npc_q  <= '0;
    end else begin
      id_q       <= id_d;
      ex_q       <= ex_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
      mem_npc_q  <= ex_q.npc;
    end
  end

  assign ex_alu_output = ex_q.result;
  assign ex_npc        = ex_q.npc;
  assign mem_npc       = mem_npc_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg        = wb_reg_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_id_exe_mem_pipe.sv
module tb_id_exe_mem_pipe;

  logic        clk;
  logic        reset;
  logic [15:0] regs [8];
  logic [19:0] instr;
  logic [7:0]  npc;
  logic [15:0] ex_alu_output;
  logic [7:0]  ex_npc;
  logic [7:0]  mem_npc;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;

  int total = 0;
  int bad   = 0;

  id_exe_mem_pipe dut (
    .clkwire             (clk),
    .reset               (reset),
    .regwire1            (regs[0]),
    .regwire2            (regs[1]),
    .regwire3            (regs[2]),
    .regwire4            (regs[3]),
    .regwire5            (regs[4]),
    .regwire6            (regs[5]),
    .regwire7            (regs[6]),
    .regwire8            (regs[7]),
    .current_instruction (instr),
    .npc_in              (npc),
    .ex_alu_output       (ex_alu_output),
    .ex_npc              (ex_npc),
    .mem_npc             (mem_npc),
    .wb_valid            (wb_valid),
    .wb_reg              (wb_reg),
    .wb_data             (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instruction is fully evaluated when it is issued; the model then
  // just delays it by two slots and applies its memory effect on retirement.
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  line;
    logic [15:0] alu;
    logic [15:0] stdata;
    logic [7:0]  npc;
  } rec_t;

  rec_t        inflight [$];
  logic [15:0] m_mem [16];
  bit          ready = 0;
  logic [15:0] e_ex_alu;
  logic [7:0]  e_ex_npc, e_mem_npc;
  logic        e_wb_valid;
  logic [3:0]  e_wb_reg;
  logic [15:0] e_wb_data;

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] imm);
    int unsigned r;
    case (op)
      4'd1:    r = a + b;
      4'd2:    r = 32'h10000 + a - b;
      4'd3:    r = a + imm;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = a ^ b;
      4'd7:    r = 16'hFFFF - a;
      4'd8:    r = a * (2 ** imm[3:0]);
      4'd9:    r = a / (2 ** imm[3:0]);
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic rec_t nop_rec();
    rec_t r;
    r.op = 0; r.rd = 0; r.line = 0; r.alu = 0; r.stdata = 0; r.npc = 0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      inflight.delete();
      inflight.push_back(nop_rec());
      inflight.push_back(nop_rec());
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      e_mem_npc = 0; e_wb_valid = 0; e_wb_reg = 0; e_wb_data = 0;
      ready = 1;
    end else if (ready) begin
      rec_t n, old;
      old = inflight.pop_front();
      e_mem_npc  = old.npc;
      e_wb_valid = 0; e_wb_reg = 0; e_wb_data = 0;
      if (old.op >= 1 && old.op <= 9) begin
        e_wb_valid = 1; e_wb_reg = old.rd; e_wb_data = old.alu;
      end else if (old.op == 4'hA) begin
        e_wb_valid = 1; e_wb_reg = old.rd; e_wb_data = m_mem[old.line];
      end else if (old.op == 4'hB) begin
        m_mem[old.line] = old.stdata;
      end
      n.op     = instr[19:16];
      n.rd     = instr[15:12];
      n.line   = instr[3:0];
      n.stdata = regs[instr[6:4]];
      n.alu    = alu_ref(n.op, regs[instr[10:8]], regs[instr[6:4]], instr[7:0]);
      n.npc    = npc;
      inflight.push_back(n);
    end
    if (ready) begin
      e_ex_alu = inflight[0].alu;
      e_ex_npc = inflight[0].npc;
    end
    #1;
    if (ready) begin
      chk("ex_alu_output", ex_alu_output, e_ex_alu);
      chk("ex_npc", ex_npc, e_ex_npc);
      chk("mem_npc", mem_npc, e_mem_npc);
      chk("wb_valid", wb_valid, e_wb_valid);
      chk("wb_reg", wb_reg, e_wb_reg);
      chk("wb_data", wb_data, e_wb_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [19:0] i, input logic [7:0] n, input logic r);
    @(negedge clk);
    instr = i; npc = n; reset = r;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_wb(input string name, input logic v, input logic [3:0] rg, input logic [15:0] d);
    chk({name, ".valid"}, wb_valid, v);
    if (v) begin
      chk({name, ".reg"}, wb_reg, rg);
      chk({name, ".data"}, wb_data, d);
    end
  endtask

  initial begin
    reset = 1'b1; instr = '0; npc = '0;
    for (int i = 0; i < 8; i++) regs[i] = 16'(5 + i);

    // Reset, then drain
    tick(20'h0, 8'h0, 1'b1);
    tick(20'h0, 8'h0, 1'b1);
    chk("rst.ex_alu", ex_alu_output, 0);
    chk("rst.ex_npc", ex_npc, 0);
    chk("rst.mem_npc", mem_npc, 0);
    for (int k = 0; k < 3; k++) begin
      tick(20'h0, 8'h0, 1'b0);
      chk_wb("drain", 1'b0, 0, 0);
    end

    // ADD rd=1 rs1=2 rs2=3
    tick(20'h11230, 8'd2, 1'b0);
    tick(20'h0, 8'd0, 1'b0);
    chk("add.ex_alu", ex_alu_output, 15);
    chk("add.ex_npc", ex_npc, 2);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("add", 1'b1, 1, 15);
    chk("add.mem_npc", mem_npc, 2);

    // Back-to-back
    tick(20'h22700, 8'd3, 1'b0);   // SUB r2 = R7-R0
    tick(20'h34010, 8'd4, 1'b0);   // ADDI r4 = R0+0x10
    tick(20'h85103, 8'd5, 1'b0);   // SHL r5 = R1<<3
    chk_wb("b2b.sub", 1'b1, 2, 16'd7);
    tick(20'h26070, 8'd6, 1'b0);   // SUB r6 = R0-R7
    chk_wb("b2b.addi", 1'b1, 4, 16'd21);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("b2b.shl", 1'b1, 5, 16'd48);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("b2b.sub2", 1'b1, 6, 16'hFFF9);

    // ST then LD same line
    tick(20'hB0075, 8'd7, 1'b0);
    tick(20'hA3005, 8'd8, 1'b0);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("st", 1'b0, 0, 0);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("ld", 1'b1, 3, 16'd12);

    // Opcode F and NOP do nothing; memory line 5 keeps 12
    tick(20'hF3015, 8'd9, 1'b0);
    tick(20'h03015, 8'd9, 1'b0);
    tick(20'hA2005, 8'd10, 1'b0);
    chk_wb("opF", 1'b0, 0, 0);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("nop", 1'b0, 0, 0);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("ld_keep", 1'b1, 2, 16'd12);

    // Reset while ADD is in EX
    tick(20'h11230, 8'd9, 1'b0);
    tick(20'h0, 8'd0, 1'b0);
    tick(20'h0, 8'd0, 1'b1);
    chk("rst2.ex_alu", ex_alu_output, 0);
    chk("rst2.ex_npc", ex_npc, 0);
    chk("rst2.mem_npc", mem_npc, 0);
    chk_wb("rst2", 1'b0, 0, 0);
    tick(20'hA1005, 8'd0, 1'b0);   // LD r1 from cleared line 5
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("rst2.drop", 1'b0, 0, 0);
    tick(20'h0, 8'd0, 1'b0);
    chk_wb("rst2.memclr", 1'b1, 1, 16'd0);

    // Randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic [19:0] ri;
      ri = 20'($urandom);
      if ($urandom_range(0, 3) != 0) ri[3:2] = 2'b00;
      if ($urandom_range(0, 2) == 0) ri[19:16] = 4'($urandom_range(10, 11));
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      tick(ri, 8'($urandom), ($urandom_range(0, 63) == 0));
    end
    tick(20'h0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
